// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake and completion status between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_ack_err;
  logic       tx_timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_ack_err, tx_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one
// odd-parity byte out on device clock falls and reports ACK, NACK or timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         board_clk,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int FW = (FILTER_LEN > 1)     ? $clog2(FILTER_LEN)     : 1;
  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

  // Index 0 carries ps2_clk, index 1 carries ps2_data.
  logic [1:0]         s1_q, s2_q, filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;
  logic               fall;

  state_t        state_q;
  logic [9:0]    sh_q;
  logic [3:0]    bitcnt_q;
  logic [IW-1:0] cnt_q;
  logic [TW-1:0] tcnt_q;
  logic          ack_n_q;
  logic          ready_q, busy_q, done_q, ackerr_q, tout_q;
  logic          clk_oe_q, data_oe_q;
  logic          complete;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FW'(FILTER_LEN - 1)) filt_d[i] = s2_q[i];
        else                                   fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 2'b11;
      s2_q   <= 2'b11;
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      s1_q   <= {ps2_data_in, ps2_clk_in};
      s2_q   <= s1_q;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign fall     = filt_q[0] & ~filt_d[0];
  assign complete = (state_q == WAIT_IDLE) && filt_q[0] && filt_q[1];

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      ack_n_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ackerr_q  <= 1'b0;
      tout_q    <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      ackerr_q <= 1'b0;
      tout_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q   <= 1'b1;
          busy_q    <= 1'b0;
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          if (tx.tx_valid && ready_q) begin
            sh_q     <= {1'b1, ~^tx.tx_data, tx.tx_data};
            clk_oe_q <= 1'b1;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b1;
            tcnt_q    <= '0;
            state_q   <= REQ;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (complete) begin
            done_q   <= ~ack_n_q;
            ackerr_q <= ack_n_q;
            state_q  <= IDLE;
          end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            tout_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
            if (fall && state_q == REQ) begin
              data_oe_q <= ~sh_q[0];
              sh_q      <= {1'b0, sh_q[9:1]};
              bitcnt_q  <= 4'd1;
              state_q   <= SEND;
            end else if (fall && state_q == SEND) begin
              if (bitcnt_q < 4'd10) begin
                data_oe_q <= ~sh_q[0];
                sh_q      <= {1'b0, sh_q[9:1]};
                bitcnt_q  <= bitcnt_q + 1'b1;
              end else begin
                // Eleventh fall: the device is holding its ACK on the data line.
                ack_n_q   <= filt_q[1];
                data_oe_q <= 1'b0;
                state_q   <= WAIT_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  assign tx.tx_ready   = ready_q;
  assign tx.busy       = busy_q;
  assign tx.tx_done    = done_q;
  assign tx.tx_ack_err = ackerr_q;
  assign tx.tx_timeout = tout_q;
  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_data_oe   = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a device model clocks frames out of the DUT and
// independent monitors compare decoded frames and completion pulses against queued expectations.
module tb_ps2_host_tx;
  localparam int INH = 120;
  localparam int TMO = 6000;
  localparam int FLT = 8;
  localparam int H   = 40;

  localparam logic [2:0] O_DONE = 3'b001;
  localparam logic [2:0] O_NACK = 3'b010;
  localparam logic [2:0] O_TOUT = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();
  logic clk_oe, data_oe;
  logic bfm_clk_low, bfm_data_low;
  logic ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(clk_oe | bfm_clk_low);
  assign ps2_data_line = ~(data_oe | bfm_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .board_clk  (clk),
    .reset      (rst),
    .tx         (bus),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (clk_oe),
    .ps2_data_oe(data_oe)
  );

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_frame[$];
  logic [10:0] got_frame[$];
  logic [2:0]  exp_out[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got expired wait bound required DUT event", name);
  endtask

  // Completion monitor: every pulse must match the oldest expected outcome.
  initial begin
    logic       pend;
    logic [2:0] code;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("ready_after_pulse", 32'(bus.tx_ready), 32'(1));
        check("busy_after_pulse", 32'(bus.busy), 32'(0));
        pend = 1'b0;
      end
      if (!rst && (bus.tx_done || bus.tx_ack_err || bus.tx_timeout)) begin
        code = {bus.tx_timeout, bus.tx_ack_err, bus.tx_done};
        if (exp_out.size() == 0) check("unexpected_outcome", 32'(code), 32'(0));
        else                     check("outcome", 32'(code), 32'(exp_out.pop_front()));
        pend = 1'b1;
      end
    end
  end

  // Frame monitor: bits decoded by the device model against queued frames.
  initial begin
    logic [10:0] g;
    forever begin
      @(negedge clk);
      while (got_frame.size() > 0) begin
        g = got_frame.pop_front();
        if (exp_frame.size() == 0) check("unexpected_frame", 32'(g), 32'(0));
        else                       check("frame_bits", 32'(g), 32'(exp_frame.pop_front()));
      end
    end
  end

  // Inhibit monitor: clock held low for exactly INH cycles, start bit driven on release.
  initial begin
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (rst) n = 0;
      else if (clk_oe) n++;
      else if (n > 0) begin
        check("inhibit_len", 32'(n), 32'(INH));
        check("start_bit_drive", 32'(data_oe), 32'(1));
        n = 0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got simulation time limit required $finish");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [7:0] b, input logic par, input logic [2:0] outc, input bit frame);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.tx_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) fail_bound("ready_before_issue");
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    exp_out.push_back(outc);
    if (frame) exp_frame.push_back({1'b1, par, b, 1'b0});
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("ready_low_on_accept", 32'(bus.tx_ready), 32'(0));
    check("busy_on_accept", 32'(bus.busy), 32'(1));
  endtask

  task automatic wait_request(output bit ok);
    int w;
    w = 0;
    ok = 1'b1;
    while (!(clk_oe == 1'b0 && data_oe == 1'b1) && w < INH + 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= INH + 100) begin
      fail_bound("request_seen");
      ok = 1'b0;
    end
  endtask

  task automatic bfm_frame(input bit ack, input bit glitch, input int abort_at);
    logic [10:0] f;
    bit ok;
    wait_request(ok);
    if (!ok) return;
    f    = '0;
    f[0] = ps2_data_line;
    repeat (H) @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      bfm_clk_low = 1'b1;
      if (k == abort_at) begin
        repeat (20) @(negedge clk);
        return;
      end
      repeat (H) @(negedge clk);
      bfm_clk_low = 1'b0;
      f[k] = ps2_data_line;
      if (k == 10 && ack) bfm_data_low = 1'b1;
      if (glitch && k == 3) begin
        repeat (15) @(negedge clk);
        bfm_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        bfm_clk_low = 1'b0;
        repeat (H - 18) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    got_frame.push_back(f);
    bfm_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    bfm_clk_low = 1'b0;
    repeat (H) @(negedge clk);
    bfm_data_low = 1'b0;
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!bus.tx_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) fail_bound("ready_after_frame");
  endtask

  typedef struct {
    logic [7:0] b;
    logic       par;
    bit         ack;
  } vec_t;

  vec_t vecs[4] = '{
    '{8'hED, 1'b1, 1'b1},
    '{8'hFF, 1'b1, 1'b1},
    '{8'h00, 1'b1, 1'b1},
    '{8'hF4, 1'b0, 1'b0}
  };

  initial begin
    bit ok;
    int n;
    bit seen;
    rst          = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bfm_clk_low  = 1'b0;
    bfm_data_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(bus.tx_ready), 32'(1));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_pulses", 32'({bus.tx_done, bus.tx_ack_err, bus.tx_timeout}), 32'(0));
    check("rst_oe", 32'({clk_oe, data_oe}), 32'(0));

    foreach (vecs[i]) begin
      issue(vecs[i].b, vecs[i].par, vecs[i].ack ? O_DONE : O_NACK, 1'b1);
      bfm_frame(vecs[i].ack, 1'b0, 0);
      wait_ready();
    end

    // Device never clocks: abort after TMO cycles from request.
    issue(8'hE6, 1'b0, O_TOUT, 1'b0);
    wait_request(ok);
    n = 0;
    while (n < TMO + 100) begin
      @(negedge clk);
      n++;
      if (bus.tx_timeout) break;
    end
    check("timeout_latency", 32'(n), 32'(TMO));
    check("timeout_oe", 32'({clk_oe, data_oe}), 32'(0));
    wait_ready();

    // Reset in the middle of a frame, then a clean frame.
    issue(8'h96, 1'b1, O_DONE, 1'b1);
    bfm_frame(1'b1, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    check("abort_oe", 32'({clk_oe, data_oe}), 32'(0));
    check("abort_ready", 32'(bus.tx_ready), 32'(1));
    void'(exp_out.pop_back());
    void'(exp_frame.pop_back());
    bfm_clk_low  = 1'b0;
    bfm_data_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(8'h55, 1'b1, O_DONE, 1'b1);
    bfm_frame(1'b1, 1'b0, 0);
    wait_ready();

    // Clock glitch mid-frame and a request pulse while busy.
    issue(8'hA5, 1'b1, O_DONE, 1'b1);
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bfm_frame(1'b1, 1'b1, 0);
    wait_ready();
    seen = 1'b0;
    repeat (2 * INH) begin
      @(negedge clk);
      if (clk_oe || bus.busy) seen = 1'b1;
    end
    check("no_second_frame", 32'(seen), 32'(0));

    check("outcomes_left", 32'(exp_out.size()), 32'(0));
    check("frames_left", 32'(exp_frame.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
